// File: rtl/serial_cmp_pkg.sv
// Shared types for the serial magnitude comparator.
//   state_t   : controller states (IDLE, SCAN, DONE)
//   result_t  : 2-bit comparison result encoding (GT, EQ, LT)
//   res_to_flags : result -> {gt, eq, lt} one-hot flag vector
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GT = 2'b00,
    EQ = 2'b01,
    LT = 2'b10
  } result_t;

  function automatic logic [2:0] res_to_flags(input result_t r);
    logic [2:0] f;
    f = '0;
    case (r)
      GT:      f = 3'b100;
      EQ:      f = 3'b010;
      LT:      f = 3'b001;
      default: f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/serial_cmp_bit_decide.sv
// Combinational decision for one bit pair of the serial scan.
//   a_bit, b_bit : current bit of each operand
//   is_msb       : bit under test is the sign position
//   signed_mode  : two's-complement compare when high
//   differ       : bits differ, this position decides the result
//   a_wins       : A is the greater operand (valid only when differ)
module serial_cmp_bit_decide (
  input  logic a_bit,
  input  logic b_bit,
  input  logic is_msb,
  input  logic signed_mode,
  output logic differ,
  output logic a_wins
);

  always_comb begin
    differ = a_bit ^ b_bit;
    // At the sign bit of a signed compare a set bit means negative, so the
    // operand holding the 0 is the larger one.
    a_wins = (is_msb && signed_mode) ? ~a_bit : a_bit;
  end

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator, MSB first, one bit per cycle.
//   clk, reset   : clock, synchronous active-high reset
//   start        : request a compare (ignored while busy)
//   a, b         : W-bit operands, captured on acceptance
//   signed_mode  : two's-complement compare, captured on acceptance
//   busy         : scan in progress
//   done         : one-cycle pulse, result flags valid
//   a_gt_b, a_eq_b, a_lt_b : registered result flags, held until next result
// EARLY_EXIT=1 stops at the first differing bit; EARLY_EXIT=0 always scans
// all W bits so latency does not depend on the operands.
module serial_mag_comparator
  import serial_cmp_pkg::*;
#(
  parameter int W          = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         signed_mode,
  output logic         busy,
  output logic         done,
  output logic         a_gt_b,
  output logic         a_eq_b,
  output logic         a_lt_b
);

  localparam int IDX_W = $clog2(W);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(W - 1);

  state_t           state, state_nxt;
  logic [W-1:0]     a_q, b_q;
  logic             sm_q;
  logic [IDX_W-1:0] idx;
  logic             found_q;
  result_t          first_q;

  logic    bit_differ, bit_a_wins;
  logic    accept;
  logic    scan_end;
  result_t bit_res;
  result_t final_res;

  serial_cmp_bit_decide u_decide (
    .a_bit       (a_q[idx]),
    .b_bit       (b_q[idx]),
    .is_msb      (idx == IDX_MSB),
    .signed_mode (sm_q),
    .differ      (bit_differ),
    .a_wins      (bit_a_wins)
  );

  always_comb begin
    accept    = start && (state != SCAN);
    bit_res   = bit_a_wins ? GT : LT;
    scan_end  = 1'b0;
    final_res = EQ;
    if (EARLY_EXIT) begin
      if (bit_differ) begin
        scan_end  = 1'b1;
        final_res = bit_res;
      end else if (idx == '0) begin
        scan_end  = 1'b1;
      end
    end else begin
      // The first difference is latched in found_q/first_q; on the final
      // bit it may also be the current bit, so merge it in here.
      scan_end = (idx == '0);
      if (found_q)         final_res = first_q;
      else if (bit_differ) final_res = bit_res;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (scan_end) state_nxt = DONE;
      DONE:    state_nxt = start ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
    busy = (state == SCAN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      sm_q    <= 1'b0;
      idx     <= '0;
      found_q <= 1'b0;
      first_q <= EQ;
      a_gt_b  <= 1'b0;
      a_eq_b  <= 1'b0;
      a_lt_b  <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      sm_q    <= signed_mode;
      idx     <= IDX_MSB;
      found_q <= 1'b0;
    end else if (state == SCAN) begin
      if (idx != '0) idx <= idx - IDX_W'(1);
      if (!found_q && bit_differ) begin
        found_q <= 1'b1;
        first_q <= bit_res;
      end
      if (scan_end) {a_gt_b, a_eq_b, a_lt_b} <= res_to_flags(final_res);
    end
  end

endmodule

// File: doc/serial_mag_comparator.md
SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

Interface
REQ-001 Parameter W, default 8, operand width in bits; legal range 2..32.
REQ-002 Parameter EARLY_EXIT, default 1; 1 = stop at first differing bit, 0 = always scan all W bits (constant time).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a comparison; sampled only when not busy.
REQ-006 a  input  W  operand A; sampled on the accepted-start edge.
REQ-007 b  input  W  operand B; sampled on the accepted-start edge.
REQ-008 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with operands.
REQ-009 busy  output  1  high while the scan is in progress.
REQ-010 done  output  1  one-cycle pulse; result valid.
REQ-011 a_gt_b, a_eq_b, a_lt_b  output  1 each  registered result flags, one-hot after the first completion.

Function
REQ-012 The FSM SHALL have three states: IDLE, SCAN, DONE; busy = (state==SCAN), done = (state==DONE).
REQ-013 start SHALL be accepted in IDLE or DONE: latch a, b, signed_mode, set index to W-1, go to SCAN; start in SCAN SHALL be ignored.
REQ-014 In SCAN, each cycle SHALL examine the bit pair at index, MSB first, exactly one bit per cycle.
REQ-015 Unsigned decision at a differing bit: a-bit 1 -> gt, a-bit 0 -> lt.
REQ-016 Signed decision at a differing bit with index W-1: a-bit 1 -> lt, a-bit 0 -> gt; lower bits are decided as unsigned.
REQ-017 With EARLY_EXIT=1, the first differing bit SHALL end the scan; state goes to DONE on that edge.
REQ-018 With EARLY_EXIT=0, the first differing bit SHALL be recorded, later bits SHALL NOT change it, and the scan SHALL end only after index 0.
REQ-019 If all W bits are equal, the result SHALL be eq after index 0 is examined.
REQ-020 Latency: for a start accepted at edge t, done SHALL be high in the cycle after edge t+k, where k = number of bits examined (1..W; always W when EARLY_EXIT=0).
REQ-021 Result flags SHALL update on the same edge that enters DONE and SHALL hold until the next completion.
REQ-022 DONE SHALL last exactly one cycle; without start it SHALL return to IDLE; with start it SHALL go to SCAN (back-to-back, no idle cycle).
REQ-023 Input changes on a, b and signed_mode after acceptance SHALL NOT affect the comparison in progress.

Reset
REQ-024 On reset the state SHALL go to IDLE, and busy, done, a_gt_b, a_eq_b and a_lt_b SHALL all be 0 from the next cycle.
REQ-025 Reset SHALL take priority over start, and reset during SCAN SHALL abort the comparison with no done pulse.
REQ-026 The first start after reset release SHALL be accepted normally.

Structure
REQ-027 The shared package serial_cmp_pkg SHALL hold the state enum (IDLE/SCAN/DONE) and the result encoding (GT/EQ/LT, 2-bit).
REQ-028 The single sub-module serial_cmp_bit_decide SHALL be combinational: inputs a-bit, b-bit, is_msb, signed_mode; outputs differ and a_wins.
REQ-029 The index counter SHALL be ceil(log2(W)) bits wide and SHALL stop at 0 without underflow.

Verification
REQ-030 W=8, EARLY_EXIT=1, unsigned, a=0x80, b=0x7F: done 1 cycle after start with gt=1, eq=0, lt=0, and busy high for exactly 1 cycle.
REQ-031 W=8, a=b=0x5A: done 8 cycles after start with eq=1.
REQ-032 W=8, signed, a=0x80 (-128), b=0x01: lt=1 after 1 cycle; the same operands unsigned give gt=1.
REQ-033 W=8, EARLY_EXIT=0, a=0x03, b=0x02: done exactly 8 cycles after start with gt=1, and a mid-scan change of a/b has no effect.
REQ-034 Reset asserted 3 cycles into a W=8 scan: no done pulse, all outputs 0, and a new start accepted on the cycle after release.
REQ-035 start held high continuously: it is ignored during SCAN, comparisons run back-to-back from DONE, and one done pulse occurs per comparison.
